port_array_rr_arbiter: RTL and testbench
========================================

// Module: port_array_rr_arbiter
// PURPOSE
//  Shares one downstream val/rdy channel between nports upstream val/rdy
//  requesters presented as unpacked port arrays (in_msg[nports]).
//  Round-robin arbitration with optional burst locking.
//  Registered single-entry output stage supports one message per cycle.
//  Sits in front of a shared resource, e.g. a memory port or a network link.
// PARAMETERS
//  nports     2   number of requesters (>=2)
//  nbits      32  message width
//  max_burst  1   max consecutive grants to one owner (>=1; 1 = pure RR)
// PORTS
//  clk        in   1                 clock, rising edge
//  reset_n    in   1                 asynchronous active-low reset
//  in_val     in   [nports]          per-port request valid
//  in_rdy     out  [nports]          per-port accept (at most one high)
//  in_msg     in   [nbits] x nports  per-port message (unpacked array)
//  out_val    out  1                 output register valid
//  out_rdy    in   1                 downstream accept
//  out_msg    out  [nbits]           registered message
//  out_src    out  [$clog2(nports)]  index of port that supplied out_msg
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   out_val=0, out_msg=0, out_src=0, ptr=0, owner=0, burst_cnt=0.
//   Any in-flight message in the output register is discarded.
//  Transfers:
//   - Input transfer on port i when in_val[i] && in_rdy[i].
//   - Output transfer when out_val && out_rdy.
//  can_acc = !out_val || out_rdy  (pipeline; no bubble at full rate).
//  Selection (combinational):
//   - lock = burst_cnt!=0 && burst_cnt<max_burst && in_val[owner].
//   - lock -> sel=owner.
//   - else sel = first i with in_val[i], scanning ptr, ptr+1, ..., nports-1,
//     0, ..., ptr-1 (wraps).
//  in_rdy[i] = can_acc && any(in_val) && i==sel. in_rdy depends on in_val.
//  On an input transfer from port s (edge):
//   - out_msg<=in_msg[s]; out_src<=s; out_val<=1; ptr<=(s+1)%nports.
//   - s==owner && burst_cnt!=0 && burst_cnt<max_burst -> burst_cnt++.
//   - otherwise -> owner<=s, burst_cnt<=1.
//  Output transfer with no input transfer in the same cycle: out_val<=0.
//  Simultaneous output and input transfer: the register is replaced; the new
//   message is valid the next cycle. Latency 1 cycle; throughput 1/cycle.
//  No request while can_acc: burst_cnt<=0 (lock released).
//  !can_acc (stall): ptr, owner, burst_cnt, out_* all hold; in_rdy all 0.
//  Owner drops in_val mid-burst: lock=0, so RR resumes from ptr in the
//   same cycle.
//  burst_cnt==max_burst: lock=0. If owner still requests it is granted
//   only when the RR scan reaches it; this yields to any other requester.
//  ptr wraps: nports-1 -> 0.
//  out_msg/out_src are don't-care when out_val=0, but they hold the last
//   value.
// TESTING
//  1 Reset mid-transfer: out_val=1 held with out_rdy=0, pulse reset_n=0 ->
//    out_val=0 immediately (async); ptr=0; next grant goes to lowest valid
//    port.
//  2 nports=4, max_burst=1, all in_val=1, out_rdy=1 ->
//    out_src=0,1,2,3,0,... one per cycle, with in_rdy one-hot each cycle.
//  3 max_burst=3, ports 0 and 2 always valid, out_rdy=1 ->
//    out_src=0,0,0,2,2,2,0,0,0.
//  4 Backpressure: out_rdy=0 for 5 cycles with requests pending ->
//    out_msg/out_src stable; in_rdy=0. After out_rdy=1, stream resumes
//    with no loss or duplication (scoreboard per port).
//  5 max_burst=4, owner=1 drops in_val after 2 grants, port 3 valid ->
//    next grant goes to port 3 with burst_cnt=1.
//  6 Random in_val/out_rdy, 10k cycles ->
//    - per-port messages arrive in order, none lost;
//    - never more than one in_rdy high;
//    - no valid port starves for more than nports*max_burst grants.

Source files
------------

// File: rtl/port_array_rr_arbiter.sv
// ============================================================================
//  port_array_rr_arbiter : round-robin val/rdy arbiter with burst locking
//  Revision: 1.0
// ============================================================================
`default_nettype none

module port_array_rr_arbiter #(
    parameter int nports    = 2,
    parameter int nbits     = 32,
    parameter int max_burst = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [nports-1:0]          in_val,
    output logic [nports-1:0]          in_rdy,
    input  logic [nbits-1:0]           in_msg [nports],
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [nbits-1:0]           out_msg,
    output logic [$clog2(nports)-1:0]  out_src
);

    localparam int                   c_src_w = $clog2(nports);
    localparam int                   c_cnt_w = $clog2(max_burst + 1);
    localparam logic [c_cnt_w-1:0]   c_max   = c_cnt_w'(max_burst);
    localparam logic [c_src_w-1:0]   c_last  = c_src_w'(nports - 1);
    localparam logic [c_src_w:0]     c_n     = (c_src_w + 1)'(nports);

    logic [c_src_w-1:0] r_ptr;
    logic [c_src_w-1:0] r_owner;
    logic [c_cnt_w-1:0] r_burst_cnt;

    logic               w_can_acc;
    logic               w_any;
    logic               w_lock;
    logic               w_xfer;
    logic               w_found;
    logic [c_src_w:0]   w_scan;
    logic [c_src_w-1:0] w_rr_sel;
    logic [c_src_w-1:0] w_sel;

    assign w_can_acc = !out_val || out_rdy;
    assign w_any     = |in_val;
    assign w_lock    = (r_burst_cnt != '0) && (r_burst_cnt < c_max) && in_val[r_owner];
    assign w_sel     = w_lock ? r_owner : w_rr_sel;
    assign w_xfer    = w_can_acc && w_any;

    // Wrapping scan starting at r_ptr; the extra bit keeps ptr+k from overflowing.
    always_comb begin
        w_found  = 1'b0;
        w_rr_sel = r_ptr;
        w_scan   = '0;
        for (int k = 0; k < nports; k++) begin
            w_scan = {1'b0, r_ptr} + (c_src_w + 1)'(k);
            if (w_scan >= c_n) begin
                w_scan = w_scan - c_n;
            end
            if (!w_found && in_val[w_scan[c_src_w-1:0]]) begin
                w_found  = 1'b1;
                w_rr_sel = w_scan[c_src_w-1:0];
            end
        end
    end

    always_comb begin
        in_rdy = '0;
        if (w_xfer) begin
            in_rdy[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_val     <= 1'b0;
            out_msg     <= '0;
            out_src     <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else if (w_xfer) begin
            out_val <= 1'b1;
            out_msg <= in_msg[w_sel];
            out_src <= w_sel;
            r_ptr   <= (w_sel == c_last) ? '0 : w_sel + 1'b1;
            if ((w_sel == r_owner) && (r_burst_cnt != '0) && (r_burst_cnt < c_max)) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end else begin
                r_owner     <= w_sel;
                r_burst_cnt <= c_cnt_w'(1);
            end
        end else if (w_can_acc) begin
            // Idle while able to accept: release any burst lock.
            r_burst_cnt <= '0;
            if (out_val && out_rdy) begin
                out_val <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_port_array_rr_arbiter.sv
// ============================================================================
//  tb_port_array_rr_arbiter : randomized + directed bench with reference model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_port_array_rr_arbiter;

    localparam int N  = 4;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  in_val;
    logic          out_rdy;
    logic [N-1:0]  rdy0, rdy1;
    logic [NB-1:0] msg0 [N];
    logic [NB-1:0] msg1 [N];
    logic          ov0, ov1;
    logic [NB-1:0] om0, om1;
    logic [1:0]    os0, os1;

    always #5 clk = ~clk;

    port_array_rr_arbiter #(.nports(N), .nbits(NB), .max_burst(3)) u_dut_b3 (
        .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(rdy0), .in_msg(msg0),
        .out_val(ov0), .out_rdy(out_rdy), .out_msg(om0), .out_src(os0)
    );

    port_array_rr_arbiter #(.nports(N), .nbits(NB), .max_burst(1)) u_dut_b1 (
        .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(rdy1), .in_msg(msg1),
        .out_val(ov1), .out_rdy(out_rdy), .out_msg(om1), .out_src(os1)
    );

    // Reference model state, one slot per instance (0: max_burst 3, 1: max_burst 1)
    int            mb [2] = '{3, 1};
    int            mptr [2], mown [2], mcnt [2], mos [2];
    bit            mov [2];
    logic [NB-1:0] mom [2];
    int            seq_in [2][N];
    int            seq_out [2][N];
    int            wait_g [N];
    logic [N-1:0]  last_rdy0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int m);
        if (in_val == '0) return -1;
        if (mcnt[m] != 0 && mcnt[m] < mb[m] && in_val[mown[m]]) return mown[m];
        for (int k = 0; k < N; k++) begin
            if (in_val[(mptr[m] + k) % N]) return (mptr[m] + k) % N;
        end
        return -1;
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            mptr[m] = 0; mown[m] = 0; mcnt[m] = 0; mos[m] = 0; mov[m] = 0; mom[m] = '0;
            for (int p = 0; p < N; p++) begin
                seq_in[m][p]  = 0;
                seq_out[m][p] = 0;
            end
        end
        for (int p = 0; p < N; p++) wait_g[p] = 0;
    endtask

    // Each message carries its source port and a per-port sequence number.
    task automatic set_msgs();
        for (int p = 0; p < N; p++) begin
            msg0[p] = {2'(p), 14'(seq_in[0][p])};
            msg1[p] = {2'(p), 14'(seq_in[1][p])};
        end
    endtask

    task automatic step();
        int            s [2];
        logic [N-1:0]  er [2];
        logic          ov_d [2];
        logic [NB-1:0] om_d [2];
        logic [1:0]    os_d [2];
        #1;
        for (int m = 0; m < 2; m++) begin
            s[m]  = (!mov[m] || out_rdy) ? pick(m) : -1;
            er[m] = '0;
            if (s[m] >= 0) er[m][s[m]] = 1'b1;
        end
        chk("in_rdy_b3", 32'(rdy0), 32'(er[0]));
        chk("in_rdy_b1", 32'(rdy1), 32'(er[1]));
        ov_d = '{ov0, ov1};
        om_d = '{om0, om1};
        os_d = '{os0, os1};
        last_rdy0 = rdy0;
        if (rdy0 != '0) begin
            for (int p = 0; p < N; p++) begin
                if (rdy0[p]) begin
                    chk("starve", 32'(wait_g[p] <= N * 3), 32'd1);
                    wait_g[p] = 0;
                end else if (in_val[p]) begin
                    wait_g[p]++;
                end else begin
                    wait_g[p] = 0;
                end
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (ov_d[m] && out_rdy) begin
                chk("sb_src", 32'(om_d[m][15:14]), 32'(os_d[m]));
                chk("sb_seq", 32'(om_d[m][13:0]), 32'(14'(seq_out[m][os_d[m]])));
                seq_out[m][os_d[m]]++;
            end
            if (s[m] >= 0) begin
                mom[m] = {2'(s[m]), 14'(seq_in[m][s[m]])};
                seq_in[m][s[m]]++;
                mos[m]  = s[m];
                mov[m]  = 1'b1;
                mptr[m] = (s[m] + 1) % N;
                if (s[m] == mown[m] && mcnt[m] != 0 && mcnt[m] < mb[m]) begin
                    mcnt[m]++;
                end else begin
                    mown[m] = s[m];
                    mcnt[m] = 1;
                end
            end else if (!mov[m] || out_rdy) begin
                mcnt[m] = 0;
                if (mov[m] && out_rdy) mov[m] = 1'b0;
            end
        end
        #1;
        set_msgs();
        chk("out_val_b3", 32'(ov0), 32'(mov[0]));
        chk("out_msg_b3", 32'(om0), 32'(mom[0]));
        chk("out_src_b3", 32'(os0), 32'(mos[0]));
        chk("out_val_b1", 32'(ov1), 32'(mov[1]));
        chk("out_msg_b1", 32'(om1), 32'(mom[1]));
        chk("out_src_b1", 32'(os1), 32'(mos[1]));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mreset();
        set_msgs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int exp3 [9];
        exp3 = '{0, 0, 0, 2, 2, 2, 0, 0, 0};

        // Reset state
        reset_n = 1'b0;
        in_val  = '0;
        out_rdy = 1'b0;
        last_rdy0 = '0;
        mreset();
        set_msgs();
        #3;
        chk("rst_out_val", 32'(ov0), 32'd0);
        chk("rst_out_msg", 32'(om0), 32'd0);
        chk("rst_out_src", 32'(os0), 32'd0);
        chk("rst_in_rdy", 32'(rdy0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Pure round robin, all requesting
        do_reset();
        in_val  = '1;
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_src", 32'(os1), 32'(k % 4));
        end

        // Burst of 3 alternating between ports 0 and 2
        do_reset();
        in_val = 4'b0101;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("burst_src", 32'(os0), 32'(exp3[k]));
        end

        // Backpressure then resume
        in_val  = '1;
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_rdy", 32'(rdy0), 32'd0);
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // Owner drops mid-burst
        do_reset();
        in_val  = 4'b0010;
        out_rdy = 1'b1;
        step();
        step();
        in_val = 4'b1000;
        step();
        chk("drop_src", 32'(os0), 32'd3);
        in_val = 4'b1010;
        step();
        chk("drop_lock", 32'(os0), 32'd3);

        // Async reset with a message held in the output register
        do_reset();
        in_val  = 4'b0100;
        out_rdy = 1'b0;
        step();
        in_val = '0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_val_b3", 32'(ov0), 32'd0);
        chk("arst_out_val_b1", 32'(ov1), 32'd0);
        mreset();
        set_msgs();
        @(negedge clk);
        reset_n = 1'b1;
        in_val  = 4'b1010;
        out_rdy = 1'b1;
        step();
        chk("arst_grant", 32'(os0), 32'd1);

        // Random traffic; requests are held until accepted by the burst-3 instance
        do_reset();
        in_val    = '0;
        last_rdy0 = '0;
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int p = 0; p < N; p++) begin
                in_val[p] = (in_val[p] && !last_rdy0[p]) ? 1'b1 : ($urandom_range(0, 2) == 0);
            end
            out_rdy = ($urandom_range(0, 3) != 0);
        end

        in_val  = '0;
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) step();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < N; p++) begin
                chk("drain", 32'(seq_out[m][p]), 32'(seq_in[m][p]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
